matrix_frame_seq: RTL
=====================

// Module: matrix_frame_seq
// PURPOSE
//  Frame sequencer placed in front of the 3x3 window generator (matrix_3x3).
//  Pulls pixels from an upstream valid/ready stream (FIFO/DDR reader) and emits
//  a gated video stream (video_vs / video_de / video_data) with fixed blanking.
//  Optionally appends one zero flush line so the generator emits windows for the last image row.
// PARAMETERS
//  DW          8    pixel width
//  IMG_WIDTH   640  active pixels per line (>=3)
//  IMG_HEIGHT  480  active lines per frame (>=3)
//  VS_LEN      4    video_vs pulse length, cycles (>=1)
//  V_BLANK     16   idle cycles between vs falling and first line (>=1)
//  H_BLANK     16   idle cycles after each line, incl. last/flush line (>=1)
// PORTS
//  clk          in   1    clock
//  rst_n        in   1    reset, asynchronous, active-low
//  start        in   1    frame request pulse; sampled in IDLE only
//  busy         out  1    1 from cycle after accepted start until DONE exits
//  frame_done   out  1    one-cycle pulse at frame completion
//  s_data       in   DW   upstream pixel
//  s_valid      in   1    upstream pixel valid
//  s_ready      out  1    combinational: 1 only in ACTIVE
//  video_vs     out  1    registered frame sync to matrix_3x3
//  video_de     out  1    registered data enable to matrix_3x3
//  video_data   out  DW   registered pixel; 0 whenever video_de=0
//  line_cnt     out  11   current line index (0..IMG_HEIGHT[-1 or flush])
// BEHAVIOUR
//  Reset: state IDLE; busy, frame_done, video_vs, video_de, video_data, line_cnt, internal counters = 0.
//  States: IDLE -> VSYNC -> VBLANK -> ACTIVE <-> HBLANK -> [FLUSH -> HBLANK] -> DONE -> IDLE.
//  IDLE: start=1 -> VSYNC, pix/line counters cleared. start in other states ignored.
//  VSYNC: video_vs=1 for exactly VS_LEN cycles -> VBLANK.
//  VBLANK: V_BLANK cycles, all outputs low -> ACTIVE.
//  ACTIVE: transfer = s_valid & s_ready. Each transfer -> next cycle video_de=1, video_data=s_data
//   (latency 1). s_valid low -> video_de=0 that next cycle, no pixel lost/duplicated, no timeout.
//   pix_cnt 0..IMG_WIDTH-1 counts transfers; transfer at IMG_WIDTH-1 -> HBLANK, pix_cnt=0.
//  HBLANK: H_BLANK cycles, s_ready=0. On exit line_cnt+1; if line_cnt was < IMG_HEIGHT-1 -> ACTIVE,
//   else -> FLUSH (macro defined, not yet flushed) or DONE.
//  FLUSH: IMG_WIDTH consecutive cycles video_de=1, video_data=0, s_ready=0; then HBLANK once more.
//  DONE: one cycle, frame_done=1, busy still 1; next cycle IDLE, busy=0.
//   start asserted during DONE is ignored; earliest new frame: start in following IDLE cycle.
//  Counters 11 bit, saturate never (bounded by params); line_cnt holds final value until next start.
//  Reset mid-frame: immediate return to IDLE values; partial line discarded; next start begins line 0.
//  video_vs and video_de never both 1 in the same cycle.
// CONFIGURATION
//  MATRIX_SEQ_FLUSH_EN defined: after last image line + HBLANK, insert FLUSH line (IMG_WIDTH zeros)
//   + HBLANK; frame = IMG_HEIGHT+1 de bursts; line_cnt ends at IMG_HEIGHT+1.
//  Not defined: FLUSH state absent; frame = IMG_HEIGHT bursts; line_cnt ends at IMG_HEIGHT.
// TESTING  (IMG_WIDTH=5, IMG_HEIGHT=5, VS_LEN=2, V_BLANK=2, H_BLANK=3, DW=8)
//  1 start pulse, s_valid=1, s_data 0..24 -> vs high 2 cycles, 2 idle, 5 de bursts of 5 (0-4,...,20-24)
//    separated by 3 idle cycles; frame_done 1 cycle; busy low next cycle. With flush: 6th burst = 5 zeros.
//  2 s_valid low 2 cycles after 3rd pixel of line 1 -> de gap of 2, data stays 8,9 after 7, 25 pixels total.
//  3 start pulsed during ACTIVE and during DONE -> ignored; exactly one frame, vs pulses once.
//  4 rst_n low at line 2 pixel 3 -> all outputs 0 next edge; new start -> line_cnt=0, first pixel = next s_data.
//  5 s_valid=0 throughout ACTIVE -> busy=1, s_ready=1, video_de=0, no frame_done indefinitely.
//  6 DUT into matrix_3x3 (5x5), macro on -> matrix_de count = 25, last window center = 24.

Source files
------------

// File: rtl/matrix_frame_seq.sv
// ============================================================================
// Module   : matrix_frame_seq
// Function : Frame sequencer that pulls pixels from a valid/ready stream and
//            emits a gated video stream (vs/de/data) with fixed blanking for
//            the 3x3 window generator. Define MATRIX_SEQ_FLUSH_EN to append
//            one all-zero flush line after the last image line.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module matrix_frame_seq #(
  parameter int DW         = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int VS_LEN     = 4,
  parameter int V_BLANK    = 16,
  parameter int H_BLANK    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  input  logic [DW-1:0] s_data,
  input  logic          s_valid,
  output logic          s_ready,
  output logic          video_vs,
  output logic          video_de,
  output logic [DW-1:0] video_data,
  output logic [10:0]   line_cnt
);

  localparam int c_CW = 11;

  localparam logic [c_CW-1:0] c_VS_LAST  = c_CW'(VS_LEN - 1);
  localparam logic [c_CW-1:0] c_VB_LAST  = c_CW'(V_BLANK - 1);
  localparam logic [c_CW-1:0] c_HB_LAST  = c_CW'(H_BLANK - 1);
  localparam logic [c_CW-1:0] c_PIX_LAST = c_CW'(IMG_WIDTH - 1);
  localparam logic [c_CW-1:0] c_ROW_LAST = c_CW'(IMG_HEIGHT - 1);

  typedef enum logic [2:0] {
    c_IDLE,
    c_VSYNC,
    c_VBLANK,
    c_ACTIVE,
    c_HBLANK,
    c_DONE
`ifdef MATRIX_SEQ_FLUSH_EN
    , c_FLUSH
`endif
  } state_t;

  state_t          r_state;
  logic [c_CW-1:0] r_cnt;
  logic [c_CW-1:0] r_pix_cnt;
  logic [c_CW-1:0] r_line_cnt;
  logic            w_xfer;
  logic            w_flush_de;

`ifdef MATRIX_SEQ_FLUSH_EN
  logic            r_flushed;
  assign w_flush_de = (r_state == c_FLUSH);
`else
  assign w_flush_de = 1'b0;
`endif

  assign s_ready  = (r_state == c_ACTIVE);
  assign w_xfer   = s_valid & s_ready;
  assign line_cnt = r_line_cnt;

  // Video outputs lag the state by one cycle, so vs/de/data share one
  // pipeline stage and can never overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_IDLE;
      r_cnt      <= '0;
      r_pix_cnt  <= '0;
      r_line_cnt <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      video_vs   <= 1'b0;
      video_de   <= 1'b0;
      video_data <= '0;
`ifdef MATRIX_SEQ_FLUSH_EN
      r_flushed  <= 1'b0;
`endif
    end else begin
      video_vs   <= (r_state == c_VSYNC);
      video_de   <= w_xfer | w_flush_de;
      video_data <= w_xfer ? s_data : '0;
      frame_done <= 1'b0;

      case (r_state)
        c_IDLE: begin
          if (start) begin
            r_state    <= c_VSYNC;
            busy       <= 1'b1;
            r_cnt      <= '0;
            r_pix_cnt  <= '0;
            r_line_cnt <= '0;
`ifdef MATRIX_SEQ_FLUSH_EN
            r_flushed  <= 1'b0;
`endif
          end
        end

        c_VSYNC: begin
          if (r_cnt == c_VS_LAST) begin
            r_cnt   <= '0;
            r_state <= c_VBLANK;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        c_VBLANK: begin
          if (r_cnt == c_VB_LAST) begin
            r_cnt   <= '0;
            r_state <= c_ACTIVE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        c_ACTIVE: begin
          if (w_xfer) begin
            if (r_pix_cnt == c_PIX_LAST) begin
              r_pix_cnt <= '0;
              r_cnt     <= '0;
              r_state   <= c_HBLANK;
            end else begin
              r_pix_cnt <= r_pix_cnt + 1'b1;
            end
          end
        end

        c_HBLANK: begin
          if (r_cnt == c_HB_LAST) begin
            r_cnt      <= '0;
            r_line_cnt <= r_line_cnt + 1'b1;
            if (r_line_cnt < c_ROW_LAST) begin
              r_state <= c_ACTIVE;
`ifdef MATRIX_SEQ_FLUSH_EN
            end else if (!r_flushed) begin
              r_flushed <= 1'b1;
              r_state   <= c_FLUSH;
`endif
            end else begin
              r_state    <= c_DONE;
              frame_done <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

`ifdef MATRIX_SEQ_FLUSH_EN
        // Zero line lets the window generator emit the last image row.
        c_FLUSH: begin
          if (r_pix_cnt == c_PIX_LAST) begin
            r_pix_cnt <= '0;
            r_cnt     <= '0;
            r_state   <= c_HBLANK;
          end else begin
            r_pix_cnt <= r_pix_cnt + 1'b1;
          end
        end
`endif

        c_DONE: begin
          r_state <= c_IDLE;
          busy    <= 1'b0;
        end

        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
